active_prefix_ctrl: RTL
=======================

ACTIVE_PREFIX_CTRL -- requirements
Module: active_prefix_ctrl

Interface
REQ-001 Parameter CODEBOOK_LENGTH_MAX, default 64: active-prefix register width in bits.
REQ-002 Parameter ENCODE_DATALENGTH, default 21: codeword data width.
REQ-003 Parameter SYM_WIDTH, default 4: input symbol width; MAX_SYMS = CODEBOOK_LENGTH_MAX/SYM_WIDTH (16).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk_i and rst_i.
REQ-005 clk_i  in  1  rising-edge clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 sym_valid_i  in  1  symbol offered; sym_ready_o  out  1  symbol accepted when both are high.
REQ-008 sym_i  in  SYM_WIDTH  low-entropy symbol nibble.
REQ-009 flush_i  in  1  single-cycle flush request, honoured only in IDLE.
REQ-010 ap_cnt_o  out  6  prefix symbol count driven to the codebook.
REQ-011 ap_data_o  out  CODEBOOK_LENGTH_MAX  prefix, newest symbol in bits [3:0], zero-extended.
REQ-012 cb_match_i  in  1; cb_length_i  in  6; cb_data_i  in  ENCODE_DATALENGTH: combinational codebook result for ap_cnt_o/ap_data_o.
REQ-013 code_valid_o  out  1; code_ready_i  in  1: output handshake, transfer when both high.
REQ-014 code_length_o  out  6; code_data_o  out  ENCODE_DATALENGTH (right-aligned); code_flush_o  out  1 (beat is raw flush data).
REQ-015 overflow_o  out  1  sticky error; busy_o  out  1  high whenever state is not IDLE or count is nonzero.

Function
REQ-016 States: IDLE, LOOKUP, EMIT, FLUSH, ERR.
REQ-017 IDLE: sym_ready_o=1 unless flush_i high; on accept, prefix <= {prefix[59:0], sym_i}, count <= count+1, next LOOKUP.
REQ-018 LOOKUP (one cycle, sym_ready_o=0): if cb_match_i, register cb_length_i/cb_data_i into output regs, clear prefix and count, go EMIT; else if count==MAX_SYMS go ERR; else go IDLE.
REQ-019 Latency: symbol completing a codeword accepted in cycle N SHALL give code_valid_o=1 in cycle N+2.
REQ-020 EMIT: code_valid_o held with stable length/data until code_ready_i; on transfer return to IDLE (no bubble-free accept in the transfer cycle).
REQ-021 Flush in IDLE with count==0: no output, stay IDLE.
REQ-022 Flush in IDLE with count>0: FLUSH emits prefix MSB-first in beats of up to 5 symbols (20 bits), code_length_o=4*k, code_flush_o=1; after last beat clear prefix/count, go IDLE.
REQ-023 flush_i and sym_valid_i high in the same IDLE cycle: flush wins, symbol not accepted.
REQ-024 flush_i outside IDLE SHALL be ignored.
REQ-025 ERR: overflow_o=1, sym_ready_o=0, code_valid_o=0 until reset.
REQ-026 Count is 6 bits; never exceeds MAX_SYMS; unused prefix bits are zero.

Reset
REQ-027 On rst_i: state IDLE, prefix 0, count 0, code_valid_o=0, code_length_o=0, code_data_o=0, code_flush_o=0, overflow_o=0; sym_ready_o=1 the cycle after release.
REQ-028 Reset asserted mid-EMIT or mid-FLUSH SHALL drop the pending beat without transfer.

Structure
REQ-029 State enum, MAX_SYMS and flush chunk size (5) SHALL live in the shared coder package.
REQ-030 The codebook is external; one sub-module, flush_slicer (prefix+count -> beat length/data, remaining count), is natural.

Verification
REQ-031 Symbol F -> code_valid_o two cycles later, length 6, data 0x2D, flush 0.
REQ-032 Symbols 0,F -> no output after 0; then length 8, data 0xD4; ap_cnt_o returns to 0.
REQ-033 Symbols 2,3,F with code_ready_i low 5 cycles -> length 12, data 0xFF8 held stable, sym_ready_o low until transfer.
REQ-034 Sixteen 0 symbols -> overflow_o=1 after 16th lookup, sym_ready_o stuck 0 until rst_i.
REQ-035 Symbols 1,5 then flush_i -> one beat length 8, data 0x15, code_flush_o=1; seven symbols 1..7 then flush -> beats (20, 0x12345), (8, 0x67).
REQ-036 rst_i during EMIT, then symbol F -> no stale beat; fresh beat length 6, data 0x2D.

Source files
------------

// File: rtl/active_prefix_ctrl_pkg.sv
// Shared definitions for the active-prefix coder: FSM states, symbol capacity
// and the flush chunk size.
package active_prefix_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_EMIT   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    // Default geometry of the prefix register.
    localparam int CODEBOOK_LENGTH_MAX_DEF = 64;
    localparam int SYM_WIDTH_DEF           = 4;

    // Number of symbols a prefix register of the given width can hold.
    function automatic int max_syms(input int len_bits, input int sym_bits);
        return len_bits / sym_bits;
    endfunction

    localparam int MAX_SYMS = max_syms(CODEBOOK_LENGTH_MAX_DEF, SYM_WIDTH_DEF);

    // A flush beat carries at most this many symbols (20 bits of raw data).
    localparam int FLUSH_CHUNK_SYMS = 5;

endpackage

// File: rtl/active_prefix_ctrl_flush_slicer.sv
// Splits the oldest (most significant) chunk of the active prefix off as one
// raw flush beat and returns what is left, with the emitted symbols zeroed.
module active_prefix_ctrl_flush_slicer
    import active_prefix_ctrl_pkg::*;
#(
    parameter int CODEBOOK_LENGTH_MAX = 64,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int SYM_WIDTH           = 4
) (
    input  logic [CODEBOOK_LENGTH_MAX-1:0] prefix_i,
    input  logic [5:0]                     cnt_i,
    output logic [5:0]                     beat_len_o,
    output logic [ENCODE_DATALENGTH-1:0]   beat_data_o,
    output logic [5:0]                     rem_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] rem_prefix_o
);

    localparam int NSYM  = max_syms(CODEBOOK_LENGTH_MAX, SYM_WIDTH);
    localparam int IDX_W = $clog2(NSYM);

    logic [5:0]           take;
    logic [5:0]           rem;
    logic [SYM_WIDTH-1:0] sym_arr [NSYM];

    // Beat size is the remaining count capped at one chunk; older symbols go first.
    assign take         = (cnt_i > 6'(FLUSH_CHUNK_SYMS)) ? 6'(FLUSH_CHUNK_SYMS) : cnt_i;
    assign rem          = cnt_i - take;
    assign rem_cnt_o    = rem;
    assign beat_len_o   = take * 6'(SYM_WIDTH);

    genvar gi;
    generate
        for (gi = 0; gi < NSYM; gi++) begin : g_sym
            // Symbol slot gi (slot 0 is the newest symbol).
            assign sym_arr[gi] = prefix_i[gi*SYM_WIDTH +: SYM_WIDTH];
            // Symbols below the emitted chunk survive; everything above is cleared.
            assign rem_prefix_o[gi*SYM_WIDTH +: SYM_WIDTH] =
                (rem > 6'(gi)) ? prefix_i[gi*SYM_WIDTH +: SYM_WIDTH] : '0;
        end
        for (gi = 0; gi < FLUSH_CHUNK_SYMS; gi++) begin : g_beat
            // Beat slot gi takes the symbol sitting just above the surviving tail.
            assign beat_data_o[gi*SYM_WIDTH +: SYM_WIDTH] =
                (take > 6'(gi)) ? sym_arr[IDX_W'(rem + 6'(gi))] : '0;
        end
    endgenerate

    // Raw flush data is right-aligned; the upper codeword bits are always zero.
    assign beat_data_o[ENCODE_DATALENGTH-1:FLUSH_CHUNK_SYMS*SYM_WIDTH] = '0;

endmodule

// File: rtl/active_prefix_ctrl.sv
// Active-prefix controller: collects low-entropy symbols into a prefix,
// queries an external combinational codebook after every symbol, and emits
// either the matched codeword or, on flush, the raw prefix in chunks.
module active_prefix_ctrl
    import active_prefix_ctrl_pkg::*;
#(
    parameter int CODEBOOK_LENGTH_MAX = CODEBOOK_LENGTH_MAX_DEF,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int SYM_WIDTH           = SYM_WIDTH_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           sym_valid_i,
    output logic                           sym_ready_o,
    input  logic [SYM_WIDTH-1:0]           sym_i,
    input  logic                           flush_i,
    output logic [5:0]                     ap_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
    input  logic                           cb_match_i,
    input  logic [5:0]                     cb_length_i,
    input  logic [ENCODE_DATALENGTH-1:0]   cb_data_i,
    output logic                           code_valid_o,
    input  logic                           code_ready_i,
    output logic [5:0]                     code_length_o,
    output logic [ENCODE_DATALENGTH-1:0]   code_data_o,
    output logic                           code_flush_o,
    output logic                           overflow_o,
    output logic                           busy_o
);

    localparam int NSYM = max_syms(CODEBOOK_LENGTH_MAX, SYM_WIDTH);

    state_e                         state_q, state_d;
    logic [CODEBOOK_LENGTH_MAX-1:0] prefix_q, prefix_d;
    logic [5:0]                     cnt_q, cnt_d;
    logic                           valid_q, valid_d;
    logic [5:0]                     len_q, len_d;
    logic [ENCODE_DATALENGTH-1:0]   data_q, data_d;
    logic                           flush_q, flush_d;
    logic                           ovf_q, ovf_d;

    logic [5:0]                     beat_len;
    logic [ENCODE_DATALENGTH-1:0]   beat_data;
    logic [5:0]                     rem_cnt;
    logic [CODEBOOK_LENGTH_MAX-1:0] rem_prefix;

    active_prefix_ctrl_flush_slicer #(
        .CODEBOOK_LENGTH_MAX (CODEBOOK_LENGTH_MAX),
        .ENCODE_DATALENGTH   (ENCODE_DATALENGTH),
        .SYM_WIDTH           (SYM_WIDTH)
    ) u_slicer (
        .prefix_i     (prefix_q),
        .cnt_i        (cnt_q),
        .beat_len_o   (beat_len),
        .beat_data_o  (beat_data),
        .rem_cnt_o    (rem_cnt),
        .rem_prefix_o (rem_prefix)
    );

    assign sym_ready_o   = (state_q == ST_IDLE) && !flush_i;
    assign ap_cnt_o      = cnt_q;
    assign ap_data_o     = prefix_q;
    assign code_valid_o  = valid_q;
    assign code_length_o = len_q;
    assign code_data_o   = data_q;
    assign code_flush_o  = flush_q;
    assign overflow_o    = ovf_q;
    assign busy_o        = (state_q != ST_IDLE) || (cnt_q != 6'd0);

    // Next-state and output-register logic; every beat is loaded one cycle ahead
    // so the output holds stable while code_ready_i is low.
    always_comb begin
        state_d  = state_q;
        prefix_d = prefix_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        len_d    = len_q;
        data_d   = data_q;
        flush_d  = flush_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    if (cnt_q != 6'd0) begin
                        valid_d  = 1'b1;
                        len_d    = beat_len;
                        data_d   = beat_data;
                        flush_d  = 1'b1;
                        prefix_d = rem_prefix;
                        cnt_d    = rem_cnt;
                        state_d  = ST_FLUSH;
                    end
                end else if (sym_valid_i) begin
                    prefix_d = {prefix_q[CODEBOOK_LENGTH_MAX-SYM_WIDTH-1:0], sym_i};
                    cnt_d    = cnt_q + 6'd1;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (cb_match_i) begin
                    valid_d  = 1'b1;
                    len_d    = cb_length_i;
                    data_d   = cb_data_i;
                    flush_d  = 1'b0;
                    prefix_d = '0;
                    cnt_d    = 6'd0;
                    state_d  = ST_EMIT;
                end else if (cnt_q == 6'(NSYM)) begin
                    ovf_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (code_ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (code_ready_i) begin
                    if (cnt_q == 6'd0) begin
                        valid_d  = 1'b0;
                        flush_d  = 1'b0;
                        prefix_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        len_d    = beat_len;
                        data_d   = beat_data;
                        prefix_d = rem_prefix;
                        cnt_d    = rem_cnt;
                    end
                end
            end
            ST_ERR: begin
                valid_d = 1'b0;
                ovf_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            prefix_q <= '0;
            cnt_q    <= 6'd0;
            valid_q  <= 1'b0;
            len_q    <= 6'd0;
            data_q   <= '0;
            flush_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prefix_q <= prefix_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            len_q    <= len_d;
            data_q   <= data_d;
            flush_q  <= flush_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
